// File: rtl/parity_frame_tx_pkg.sv
// Shared types and helpers for the parity frame transmitter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package parity_pkg;

    // Frame sequencer states, in transmit order.
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    // Default word width and the matching frame length in bit periods
    // (start + data + parity + stop).
    localparam int DEF_N      = 5;
    localparam int FRAME_BITS = DEF_N + 3;

    // Widest word the parity helper accepts; narrower words are
    // zero-extended, which leaves the XOR reduction unchanged.
    localparam int PAR_MAX_W  = 64;

    // Odd parity: result makes the total count of ones (word + bit) odd.
    function automatic logic odd_par(input logic [PAR_MAX_W-1:0] word);
        return ~^word;
    endfunction

endpackage

// File: rtl/parity_frame_tx_parity_calc.sv
// Combinational N-bit parity generator (odd by default, even on request).
// Latency: 0 cycles, purely combinational.
// Backpressure: none; output follows inputs.
// Ports: data_i - word to protect; even_i - 1 selects even parity;
//        parity_o - generated parity bit.
module parity_calc #(
    parameter int N = 5
) (
    input  logic [N-1:0] data_i,
    input  logic         even_i,
    output logic         parity_o
);
    import parity_pkg::*;

    logic odd_bit;

    assign odd_bit  = odd_par(PAR_MAX_W'(data_i));
    // Even parity is simply the complement of odd parity.
    assign parity_o = even_i ? ~odd_bit : odd_bit;

endmodule

// File: rtl/parity_frame_tx.sv
// Serial frame transmitter: start, N data bits LSB-first, parity, stop.
// Latency: first start-bit cycle follows the accept edge; frame is (N+3)*BAUD_DIV cycles.
// Backpressure: in_ready only while idle; words offered mid-frame are held off.
// Ports: clk/rst (sync, active-high), in_valid/in_ready/in_data word handshake,
//        tx serial line (idles high), busy during a frame, done one-cycle end pulse.
// Optional macro PARITY_EVEN_SEL_EN adds input parity_even (1 = even parity),
// sampled at accept; without it parity is always odd.
module parity_frame_tx #(
    parameter int N        = 5,
    parameter int BAUD_DIV = 4
) (
    input  logic         clk,
    input  logic         rst,
`ifdef PARITY_EVEN_SEL_EN
    input  logic         parity_even,
`endif
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    output logic         tx,
    output logic         busy,
    output logic         done
);
    import parity_pkg::*;

    // Counter widths kept at least 1 bit so BAUD_DIV=1 / N=1 stay legal.
    localparam int BW   = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int BITW = (N > 1) ? $clog2(N) : 1;

    tx_state_t       state_q, state_d;
    logic [BW-1:0]   baud_q, baud_d;
    logic [BITW-1:0] bit_q, bit_d;
    logic [N-1:0]    shreg_q, shreg_d;
    logic            par_q, par_d;
    logic            tx_q, tx_d;
    logic            done_q, done_d;

    logic            even_sel;
    logic            par_in;
    logic            accept;
    logic            baud_wrap;

`ifdef PARITY_EVEN_SEL_EN
    assign even_sel = parity_even;
`else
    assign even_sel = 1'b0;
`endif

    parity_calc #(.N(N)) u_parity_calc (
        .data_i   (in_data),
        .even_i   (even_sel),
        .parity_o (par_in)
    );

    assign in_ready  = (state_q == IDLE) && !rst;
    assign accept    = in_valid && in_ready;
    assign baud_wrap = (baud_q == BW'(BAUD_DIV - 1));

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        done_d  = 1'b0;
        tx_d    = 1'b1;

        if (state_q == IDLE) begin
            baud_d = '0;
            bit_d  = '0;
            if (accept) begin
                shreg_d = in_data;
                par_d   = par_in;
                state_d = START;
            end
        end else begin
            baud_d = baud_wrap ? '0 : baud_q + BW'(1);
        end

        if (baud_wrap) begin
            case (state_q)
                START: begin
                    state_d = DATA;
                    bit_d   = '0;
                end
                DATA: begin
                    // Bit boundary: advance to the next data bit, or leave
                    // for parity once the last bit period has elapsed.
                    shreg_d = shreg_q >> 1;
                    if (bit_q == BITW'(N - 1)) begin
                        state_d = PARITY;
                    end else begin
                        bit_d = bit_q + BITW'(1);
                    end
                end
                PARITY: state_d = STOP;
                STOP: begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
                default: ;
            endcase
        end

        // tx is registered, so it is derived from the state being entered.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shreg_d[0];
            PARITY:  tx_d = par_d;
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    assign tx   = tx_q;
    assign busy = (state_q != IDLE);
    assign done = done_q;

endmodule

// File: tb/tb_parity_frame_tx.sv
// Self-checking bench for parity_frame_tx: two instances (BAUD_DIV=2 and 1).
// Expected per-cycle tx values are queued at stimulus time and popped per cycle.
module tb_parity_frame_tx;

    localparam int N = 5;

    logic         clk = 1'b0;
    logic         rst;
    logic         vld;
    logic         sel;   // 0 = BAUD_DIV=2 instance, 1 = BAUD_DIV=1 instance
    logic         pe;
    logic [N-1:0] din;

    logic rdy_a, tx_a, busy_a, done_a;
    logic rdy_b, tx_b, busy_b, done_b;
    logic vld_a, vld_b;
    logic rdy_o, tx_o, busy_o, done_o;

    int checks   = 0;
    int failures = 0;
    logic exp_q[$];

    always #5 clk = ~clk;

    assign vld_a  = vld & ~sel;
    assign vld_b  = vld & sel;
    assign rdy_o  = sel ? rdy_b  : rdy_a;
    assign tx_o   = sel ? tx_b   : tx_a;
    assign busy_o = sel ? busy_b : busy_a;
    assign done_o = sel ? done_b : done_a;

    parity_frame_tx #(.N(N), .BAUD_DIV(2)) dut_a (
        .clk         (clk),
        .rst         (rst),
`ifdef PARITY_EVEN_SEL_EN
        .parity_even (pe),
`endif
        .in_valid    (vld_a),
        .in_ready    (rdy_a),
        .in_data     (din),
        .tx          (tx_a),
        .busy        (busy_a),
        .done        (done_a)
    );

    parity_frame_tx #(.N(N), .BAUD_DIV(1)) dut_b (
        .clk         (clk),
        .rst         (rst),
`ifdef PARITY_EVEN_SEL_EN
        .parity_even (pe),
`endif
        .in_valid    (vld_b),
        .in_ready    (rdy_b),
        .in_data     (din),
        .tx          (tx_b),
        .busy        (busy_b),
        .done        (done_b)
    );

    task automatic chk(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, expv, $time);
        end
    endtask

    // Called at a negedge with the selected DUT idle. Returns at the negedge
    // of the done cycle, with in_valid still high when hold is set.
    task automatic run_frame(input logic [N-1:0] word, input bit hold);
        int   div;
        logic p;
        logic fb[N+3];
        logic e;
        div = sel ? 1 : 2;
        p   = pe ? ^word : ~^word;
        fb[0] = 1'b0;
        for (int i = 0; i < N; i++) fb[1+i] = word[i];
        fb[N+1] = p;
        fb[N+2] = 1'b1;
        for (int i = 0; i < N + 3; i++)
            for (int k = 0; k < div; k++) exp_q.push_back(fb[i]);

        chk("ready_before_accept", rdy_o, 1'b1);
        din = word;
        vld = 1'b1;
        @(posedge clk);
        @(negedge clk);
        // Disturb inputs after accept: the frame in flight must not change.
        din = ~word;
        pe  = ~pe;
        if (!hold) vld = 1'b0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("frame_tx", tx_o, e);
            chk("frame_busy", busy_o, 1'b1);
            chk("frame_done_low", done_o, 1'b0);
            chk("frame_not_ready", rdy_o, 1'b0);
            @(negedge clk);
        end
        chk("done_pulse", done_o, 1'b1);
        chk("done_tx_idle", tx_o, 1'b1);
        chk("done_busy_low", busy_o, 1'b0);
        chk("done_ready", rdy_o, 1'b1);
    endtask

    // One cycle after a done with nothing offered: pulse gone, line idle.
    task automatic idle_after;
        @(negedge clk);
        chk("done_single_cycle", done_o, 1'b0);
        chk("idle_tx", tx_o, 1'b1);
        chk("idle_busy", busy_o, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        vld = 1'b1;      // offered during reset: must not be accepted
        sel = 1'b0;
        pe  = 1'b0;
        din = 5'h1F;
        @(negedge clk);
        @(negedge clk);
        chk("rst_tx", tx_o, 1'b1);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_done", done_o, 1'b0);
        chk("rst_ready", rdy_o, 1'b0);
        rst = 1'b0;
        vld = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", busy_o, 1'b0);
        chk("post_rst_tx", tx_o, 1'b1);
        chk("post_rst_ready", rdy_o, 1'b1);

        // Single frames with a spread of parities.
        pe = 1'b0;
        run_frame(5'd3, 1'b0);  idle_after();
        pe = 1'b0;
        run_frame(5'd7, 1'b0);  idle_after();
        pe = 1'b0;
        run_frame(5'd9, 1'b0);  idle_after();
        pe = 1'b0;
        run_frame(5'd17, 1'b0); idle_after();
        pe = 1'b0;
        run_frame(5'd19, 1'b0); idle_after();

        // Back-to-back: in_valid held, second word accepted in the done cycle.
        pe = 1'b0;
        run_frame(5'd3, 1'b1);
        pe = 1'b0;
        run_frame(5'd9, 1'b0);
        idle_after();

        // Reset during data bit 2 of a frame.
        din = 5'h0A;
        vld = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vld = 1'b0;
        repeat (6) @(negedge clk);
        chk("abort_bit2_tx", tx_o, 1'b0);
        chk("abort_bit2_busy", busy_o, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_tx", tx_o, 1'b1);
        chk("abort_busy", busy_o, 1'b0);
        chk("abort_done", done_o, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("abort_no_done", done_o, 1'b0);
            chk("abort_stays_idle", busy_o, 1'b0);
        end
        pe = 1'b0;
        run_frame(5'h15, 1'b0);
        idle_after();

        // BAUD_DIV=1 instance: 8-cycle frame 0,1,1,1,1,1,0,1.
        sel = 1'b1;
        pe  = 1'b0;
        @(negedge clk);
        run_frame(5'h1F, 1'b0);
        idle_after();
        sel = 1'b0;

`ifdef PARITY_EVEN_SEL_EN
        // Even parity selected at accept; run_frame toggles pe mid-frame.
        pe = 1'b1;
        run_frame(5'd3, 1'b0);
        idle_after();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
